// File: rtl/proc_pkg.sv
// Shared definitions for the accumulator processor: opcodes, FSM states,
// ALU operations and instruction-field slicing helpers.
package proc_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDAC  = 4'h1;
  localparam logic [3:0] OP_STAC  = 4'h2;
  localparam logic [3:0] OP_MVAC  = 4'h3;
  localparam logic [3:0] OP_MOVR  = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_LDI   = 4'h8;
  localparam logic [3:0] OP_INC   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JMPZ  = 4'hB;
  localparam logic [3:0] OP_JMPNZ = 4'hC;
  localparam logic [3:0] OP_CLR   = 4'hD;
  localparam logic [3:0] OP_RSVD  = 4'hE;
  localparam logic [3:0] OP_END   = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_INC,
    ALU_CLR
  } alu_op_t;

  // Instruction words are widened to this size so one helper serves any ADDR_W.
  localparam int MAX_IW = 64;

  function automatic logic [3:0] opcode_of(input logic [MAX_IW-1:0] instr, input int addr_w);
    return 4'(instr >> addr_w);
  endfunction

  function automatic logic [MAX_IW-1:0] operand_of(input logic [MAX_IW-1:0] instr, input int addr_w);
    return instr & ((MAX_IW'(1) << addr_w) - MAX_IW'(1));
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational accumulator ALU with zero detect; PASS forwards operand b.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = b;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_INC: result = a + DATA_W'(1);
      ALU_CLR: result = '0;
      default: result = b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/proc_core.sv
// Multi-cycle accumulator processor: FETCH/DECODE/EXEC|MEM loop with a
// req/ack data-memory handshake and an absorbing HALT on END.
module proc_core
  import proc_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [ADDR_W+3:0] im_data,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ac_out,
  output logic              end_process
);

  localparam int IW     = ADDR_W + 4;
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t            state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ac;
  logic              z;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [3:0]        ir_op, fetch_op;
  logic [ADDR_W-1:0] operand;
  logic [RIDX_W-1:0] r_idx;
  logic              r_valid;
  logic [DATA_W-1:0] reg_val;
  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_b, alu_result;
  logic              alu_zero;

  assign ir_op    = opcode_of(MAX_IW'(ir), ADDR_W);
  assign operand  = ADDR_W'(operand_of(MAX_IW'(ir), ADDR_W));
  assign fetch_op = opcode_of(MAX_IW'(im_data), ADDR_W);
  assign r_idx    = operand[RIDX_W-1:0];
  // Non-power-of-two register counts leave some indices without a register.
  assign r_valid  = (int'(r_idx) < NUM_REGS);
  assign reg_val  = r_valid ? regs[r_idx] : '0;

  always_comb begin
    alu_op = ALU_PASS;
    alu_b  = reg_val;
    case (ir_op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_INC:  alu_op = ALU_INC;
      OP_CLR:  alu_op = ALU_CLR;
      OP_LDI:  alu_b  = DATA_W'(operand);
      default: alu_op = ALU_PASS;
    endcase
  end

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (ac),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: begin
        if (fetch_op == OP_LDAC || fetch_op == OP_STAC) next_state = ST_MEM;
        else if (fetch_op == OP_END)                    next_state = ST_HALT;
        else                                            next_state = ST_EXEC;
      end
      ST_EXEC:   next_state = ST_FETCH;
      ST_MEM:    next_state = dm_ack ? ST_FETCH : ST_MEM;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    dm_req      = 1'b0;
    dm_we       = 1'b0;
    end_process = 1'b0;
    case (state)
      ST_MEM: begin
        dm_req = 1'b1;
        dm_we  = (ir_op == OP_STAC);
      end
      ST_HALT: end_process = 1'b1;
      default: ;
    endcase
  end

  assign im_addr  = pc;
  assign pc_out   = pc;
  assign ac_out   = ac;
  assign dm_addr  = operand;
  assign dm_wdata = ac;

  // An ack only commits while in MEM, so one arriving after reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ac <= '0;
      z  <= 1'b0;
      ir <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_DECODE: begin
          ir <= im_data;
          pc <= pc + ADDR_W'(1);
        end
        ST_EXEC: begin
          case (ir_op)
            OP_MVAC:  if (r_valid) regs[r_idx] <= ac;
            OP_MOVR:  ac <= reg_val;
            OP_ADD, OP_SUB, OP_AND, OP_INC, OP_CLR, OP_LDI: begin
              ac <= alu_result;
              z  <= alu_zero;
            end
            OP_JMP:   pc <= operand;
            OP_JMPZ:  if (z)  pc <= operand;
            OP_JMPNZ: if (!z) pc <= operand;
            OP_NOP, OP_RSVD: ;
            default: ;
          endcase
        end
        ST_MEM: if (dm_ack && ir_op == OP_LDAC) ac <= dm_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core.sv
// Directed bench for proc_core: program table run to END on the default
// core, plus hand sequences for handshake stalls, reset and parameter variants.
module tb_proc_core;

  typedef struct {
    logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7;
    int          delay;
    logic [11:0] exp_ac;
    logic [11:0] exp_pc;
    int          exp_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] rom  [4096];
  logic [11:0] dmem [4096];

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   ack_delay;
  int   wait_cnt;
  logic stray_ack;

  // Default core with a bench-controlled ack latency
  logic [11:0] im_addr0, dm_addr0, dm_wdata0, dm_rdata0, pc0, ac0;
  logic [15:0] im_data0;
  logic        dm_req0, dm_we0, dm_ack0, end0;

  assign dm_ack0   = (dm_req0 && wait_cnt == ack_delay) || stray_ack;
  assign dm_rdata0 = dmem[dm_addr0];

  proc_core dut0 (
    .clk(clk), .rst(rst), .im_addr(im_addr0), .im_data(im_data0),
    .dm_req(dm_req0), .dm_we(dm_we0), .dm_addr(dm_addr0), .dm_wdata(dm_wdata0),
    .dm_rdata(dm_rdata0), .dm_ack(dm_ack0), .pc_out(pc0), .ac_out(ac0),
    .end_process(end0)
  );

  always @(posedge clk) begin
    im_data0 <= rom[im_addr0];
    if (dm_req0 && dm_ack0 && dm_we0) dmem[dm_addr0] <= dm_wdata0;
    if (!dm_req0 || dm_ack0) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  // 8-bit data variant
  logic [11:0] im_addr1, dm_addr1, pc1;
  logic [15:0] im_data1;
  logic [7:0]  dm_wdata1, ac1;
  logic        dm_req1, dm_we1, end1;

  proc_core #(.DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .im_addr(im_addr1), .im_data(im_data1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(8'h00), .dm_ack(dm_req1), .pc_out(pc1), .ac_out(ac1),
    .end_process(end1)
  );

  // 8-register variant
  logic [11:0] im_addr2, dm_addr2, dm_wdata2, pc2, ac2;
  logic [15:0] im_data2;
  logic        dm_req2, dm_we2, end2;

  proc_core #(.NUM_REGS(8)) dut2 (
    .clk(clk), .rst(rst), .im_addr(im_addr2), .im_data(im_data2),
    .dm_req(dm_req2), .dm_we(dm_we2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2),
    .dm_rdata(12'h000), .dm_ack(dm_req2), .pc_out(pc2), .ac_out(ac2),
    .end_process(end2)
  );

  always @(posedge clk) begin
    im_data1 <= rom[im_addr1];
    im_data2 <= rom[im_addr2];
  end

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7,
                              input int d, input logic [11:0] ac, pc, input int c);
    vec_t v;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
    v.w4 = w4; v.w5 = w5; v.w6 = w6; v.w7 = w7;
    v.delay = d; v.exp_ac = ac; v.exp_pc = pc; v.exp_cyc = c;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Loads the program, holds reset for two edges, checks reset outputs and
  // releases reset; cycle 1 is the first FETCH after release.
  task automatic load_and_reset(input vec_t v);
    @(negedge clk);
    rst       = 1'b1;
    stray_ack = 1'b0;
    ack_delay = v.delay;
    for (int a = 0; a < 4096; a++) rom[a] = 16'h0000;
    rom[0] = v.w0; rom[1] = v.w1; rom[2] = v.w2; rom[3] = v.w3;
    rom[4] = v.w4; rom[5] = v.w5; rom[6] = v.w6; rom[7] = v.w7;
    rom[12'h020] = 16'hF000;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_outs",
                {24'h0, |im_addr0, |pc0, |ac0, end0, dm_req0, dm_we0, |dm_addr0, |dm_wdata0},
                32'h0);
    rst = 1'b0;
    cyc = 1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    load_and_reset(v);
    while (!end0 && cyc < 200) tick();
    checkOutput($sformatf("v%0d_end_cycle", idx), cyc, v.exp_cyc);
    checkOutput($sformatf("v%0d_ac", idx), ac0, v.exp_ac);
    checkOutput($sformatf("v%0d_pc", idx), pc0, v.exp_pc);
  endtask

  vec_t vecs[7];
  vec_t hv;
  int   req_cnt, first_req, bad;

  initial begin
    rst = 1'b1; stray_ack = 1'b0; ack_delay = 0; cyc = 0;

    // LDI/MVAC/ADD sum
    vecs[0] = mk(16'h8005, 16'h3001, 16'h8003, 16'h5001, 16'hF000, 16'h0, 16'h0, 16'h0, 0, 12'h008, 12'h005, 15);
    // SUB then JMPZ not taken, then SUB to zero and JMPZ taken to 0x020 (END)
    vecs[1] = mk(16'h8001, 16'h6000, 16'hB020, 16'h3001, 16'h8001, 16'h6001, 16'hB020, 16'hF000, 0, 12'h000, 12'h021, 24);
    // STAC / CLR / LDAC round trip, same-cycle ack
    vecs[2] = mk(16'h80AB, 16'h2010, 16'hD000, 16'h1010, 16'hF000, 16'h0, 16'h0, 16'h0, 0, 12'h0AB, 12'h005, 15);
    // AND, INC, JMPNZ taken over a skipped LDI
    vecs[3] = mk(16'h80F0, 16'h3003, 16'h803C, 16'h7003, 16'h9000, 16'hC007, 16'h8FFF, 16'hF000, 0, 12'h031, 12'h008, 21);
    // MOVR and reserved opcode keep Z from CLR, so JMPZ is taken
    vecs[4] = mk(16'h8123, 16'h3000, 16'hD000, 16'h4000, 16'hE000, 16'hB007, 16'h8000, 16'hF000, 0, 12'h123, 12'h008, 21);
    // SUB underflow wraps, JMP unconditional
    vecs[5] = mk(16'h8002, 16'h3001, 16'h8001, 16'h6001, 16'hA007, 16'h0000, 16'h0000, 16'hF000, 0, 12'hFFF, 12'h008, 18);
    // Memory round trip with two wait cycles per access
    vecs[6] = mk(16'h85A5, 16'h2011, 16'hD000, 16'h1011, 16'hF000, 16'h0, 16'h0, 16'h0, 2, 12'h5A5, 12'h005, 19);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // STAC 0x010 with ack four cycles late: request fields must hold steady
    hv = mk(16'h8077, 16'h2010, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4, 12'h077, 12'h003, 13);
    load_and_reset(hv);
    req_cnt = 0; first_req = 0; bad = 0;
    while (!end0 && cyc < 40) begin
      if (dm_req0) begin
        req_cnt++;
        if (first_req == 0) first_req = cyc;
        if (dm_we0 !== 1'b1 || dm_addr0 !== 12'h010 || dm_wdata0 !== 12'h077) bad++;
      end
      tick();
    end
    checkOutput("stac_first_req_cycle", first_req, 6);
    checkOutput("stac_req_cycles", req_cnt, 5);
    checkOutput("stac_fields_stable", bad, 0);
    checkOutput("stac_end_cycle", cyc, 13);
    checkOutput("stac_mem_written", dmem[12'h010], 12'h077);

    // Reset during an LDAC wait, with a stray ack the cycle after the reset edge
    hv = mk(16'h1011, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 10, 12'h000, 12'h000, 0);
    load_and_reset(hv);
    run_to(4);
    checkOutput("ldac_req_waiting", dm_req0, 1'b1);
    checkOutput("ldac_is_read", dm_we0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("req_low_after_rst", dm_req0, 1'b0);
    rst = 1'b0;
    stray_ack = 1'b1;
    checkOutput("fetch_restart_addr", im_addr0, 12'h000);
    tick();
    stray_ack = 1'b0;
    checkOutput("ac_after_late_ack", ac0, 12'h000);
    checkOutput("pc_after_restart", pc0, 12'h000);

    // DATA_W=8: LDI truncation, INC wrap sets Z, JMP 0xFFF then wrap to 0
    hv = mk(16'h80FF, 16'h9000, 16'hB004, 16'hF000, 16'hAFFF, 16'h0, 16'h0, 16'h0, 0, 12'h000, 12'h000, 0);
    load_and_reset(hv);
    run_to(4);
    checkOutput("w8_ldi_trunc", ac1, 8'hFF);
    run_to(7);
    checkOutput("w8_inc_wrap", ac1, 8'h00);
    run_to(10);
    checkOutput("w8_jmpz_taken", im_addr1, 12'h004);
    run_to(13);
    checkOutput("w8_jmp_fff", pc1, 12'hFFF);
    run_to(15);
    checkOutput("w8_pc_wrap", pc1, 12'h000);

    // NUM_REGS=8: MVAC 0x00F writes R7 only; upper operand bits ignored on read
    hv = mk(16'h8055, 16'h300F, 16'hD000, 16'h4007, 16'h4003, 16'h4017, 16'hF000, 16'h0, 0, 12'h000, 12'h000, 0);
    load_and_reset(hv);
    run_to(13);
    checkOutput("r8_movr_r7", ac2, 12'h055);
    run_to(16);
    checkOutput("r8_movr_r3", ac2, 12'h000);
    run_to(19);
    checkOutput("r8_movr_017", ac2, 12'h055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
